// File: rtl/error_response_queue.sv
// Error-response generator: latches per-source error events, picks the
// highest-priority one each cycle and queues ERROR headers for the transmitter.
module error_response_queue #(
  parameter int                        NUM_ERRORS       = 6,
  parameter int                        HDR_VAR_W        = 8,
  parameter int                        HDR_BYTES        = 4,
  parameter int                        FIFO_DEPTH       = 4,
  parameter logic [HDR_VAR_W-1:0]      PROTOCOL_VERSION = 8'h01,
  parameter logic [HDR_VAR_W-1:0]      ERROR_RESP_CMD   = 8'h7F,
  parameter logic [NUM_ERRORS*16-1:0]  ERR_CODE_MAP     = {16'h0100, 16'h0100, 16'h0100,
                                                           16'h0300, 16'h0201, 16'h0400}
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            Enable,
  input  logic [NUM_ERRORS-1:0]           error_in,
  output logic [HDR_VAR_W*HDR_BYTES-1:0]  header,
  output logic                            msg_valid,
  input  logic                            msg_ack,
  output logic [NUM_ERRORS-1:0]           pending,
  output logic [7:0]                      drop_count
);

  localparam int HDR_W = HDR_VAR_W * HDR_BYTES;
  localparam int IDX_W = (NUM_ERRORS > 1) ? $clog2(NUM_ERRORS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [NUM_ERRORS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [7:0]            drop_q, drop_d;

  logic                  any_pend, pop, push, room;
  logic [IDX_W-1:0]      sel_idx, head_idx;
  logic [NUM_ERRORS-1:0] clr, coal;
  logic [8:0]            ndrop;
  logic [15:0]           code;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s > 10'd255) ? 8'hFF : s[7:0];
  endfunction

  // Fixed priority: lowest set index wins.
  always_comb begin
    sel_idx  = '0;
    any_pend = 1'b0;
    for (int i = NUM_ERRORS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx  = IDX_W'(i);
        any_pend = 1'b1;
      end
    end
  end

  assign pop  = Enable && (count_q != '0) && msg_ack;
  assign room = (count_q < DEPTH_C) || pop;
  assign push = Enable && any_pend && room;
  assign clr  = push ? (NUM_ERRORS'(1) << sel_idx) : '0;

  // A repeat of an already latched, not-being-cleared event is merged and counted.
  always_comb begin
    coal  = error_in & pending_q & ~clr;
    ndrop = '0;
    for (int i = 0; i < NUM_ERRORS; i++) begin
      ndrop = ndrop + 9'(coal[i]);
    end
  end

  always_comb begin
    pending_d = '0;
    wr_ptr_d  = '0;
    rd_ptr_d  = '0;
    count_d   = '0;
    drop_d    = drop_q;
    if (Enable) begin
      pending_d = (pending_q & ~clr) | error_in;
      wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
      drop_d    = sat_add8(drop_q, ndrop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drop_q    <= '0;
    end else begin
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
    end
  end

  // Storage holds only source indices; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sel_idx;
    end
  end

  assign head_idx   = mem_q[rd_ptr_q];
  assign code       = ERR_CODE_MAP[int'(head_idx) * 16 +: 16];
  assign msg_valid  = (count_q != '0);
  assign header     = msg_valid ? HDR_W'({PROTOCOL_VERSION, ERROR_RESP_CMD, code}) : '0;
  assign pending    = pending_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_error_response_queue.sv
// Bench for error_response_queue: vector table, cycle model with header scoreboard,
// and hand sequences for coalescing, wrap, flush and async reset.
module tb_error_response_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Enable;
  logic [5:0]  error_in;
  logic        msg_ack;
  logic [31:0] header;
  logic        msg_valid;
  logic [5:0]  pending;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  error_response_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Enable     (Enable),
    .error_in   (error_in),
    .header     (header),
    .msg_valid  (msg_valid),
    .msg_ack    (msg_ack),
    .pending    (pending),
    .drop_count (drop_count)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [5:0]  mpend    = '0;
  logic [7:0]  mdrop    = '0;
  int          mq[$];
  logic [31:0] sb[$];
  int          popped   = 0;

  typedef struct {
    logic [5:0]  err;
    logic        ack;
    logic        vld;
    logic [31:0] hdr;
    logic [5:0]  pend;
    logic [7:0]  drop;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [31:0] exp_hdr(input int idx);
    case (idx)
      0:       return 32'h017F0400;
      1:       return 32'h017F0201;
      2:       return 32'h017F0300;
      default: return 32'h017F0100;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge; also pops the scoreboard on a handshake.
  task automatic model_edge(input logic [5:0] err, input logic en, input logic ack);
    bit do_pop, do_push, found;
    int sel;
    if (!en) begin
      mpend = '0;
      mq.delete();
      sb.delete();
      return;
    end
    do_pop = (mq.size() != 0) && ack;
    found  = 0;
    sel    = 0;
    for (int i = 0; i < 6; i++) begin
      if (!found && mpend[i]) begin
        found = 1;
        sel   = i;
      end
    end
    do_push = found && ((mq.size() < 4) || do_pop);
    for (int i = 0; i < 6; i++) begin
      if (err[i] && mpend[i] && !(do_push && sel == i) && mdrop != 8'hFF) mdrop++;
    end
    if (do_pop) begin
      void'(mq.pop_front());
      popped++;
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else                chk("sb_header", header, sb.pop_front());
    end
    if (do_push) begin
      mq.push_back(sel);
      sb.push_back(exp_hdr(sel));
      mpend[sel] = 1'b0;
    end
    mpend = mpend | err;
  endtask

  task automatic step(input logic [5:0] err, input logic en, input logic ack);
    error_in = err;
    Enable   = en;
    msg_ack  = ack;
    #3;
    model_edge(err, en, ack);
    @(posedge clk);
    #1;
    chk("msg_valid", 32'(msg_valid), 32'(mq.size() != 0));
    chk("header", header, (mq.size() != 0) ? exp_hdr(mq[0]) : 32'h0);
    chk("pending", 32'(pending), 32'(mpend));
    chk("drop_count", 32'(drop_count), 32'(mdrop));
  endtask

  int p0;

  initial begin
    rst_n    = 1'b0;
    Enable   = 1'b0;
    error_in = '0;
    msg_ack  = 1'b0;
    #3;
    chk("rst_valid", 32'(msg_valid), 32'd0);
    chk("rst_header", header, 32'h0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single event, then priority with ack held high.
    tbl[0] = '{6'b000100, 1'b0, 1'b0, 32'h0,        6'b000100, 8'd0};
    tbl[1] = '{6'b000000, 1'b0, 1'b1, 32'h017F0300, 6'b000000, 8'd0};
    tbl[2] = '{6'b000000, 1'b0, 1'b1, 32'h017F0300, 6'b000000, 8'd0};
    tbl[3] = '{6'b000000, 1'b1, 1'b0, 32'h0,        6'b000000, 8'd0};
    tbl[4] = '{6'b100011, 1'b1, 1'b0, 32'h0,        6'b100011, 8'd0};
    tbl[5] = '{6'b000000, 1'b1, 1'b1, 32'h017F0400, 6'b100010, 8'd0};
    tbl[6] = '{6'b000000, 1'b1, 1'b1, 32'h017F0201, 6'b100000, 8'd0};
    tbl[7] = '{6'b000000, 1'b1, 1'b1, 32'h017F0100, 6'b000000, 8'd0};
    tbl[8] = '{6'b000000, 1'b1, 1'b0, 32'h0,        6'b000000, 8'd0};
    for (int r = 0; r < 9; r++) begin
      step(tbl[r].err, 1'b1, tbl[r].ack);
      chk($sformatf("tbl%0d_valid", r), 32'(msg_valid), 32'(tbl[r].vld));
      chk($sformatf("tbl%0d_header", r), header, tbl[r].hdr);
      chk($sformatf("tbl%0d_pending", r), 32'(pending), 32'(tbl[r].pend));
      chk($sformatf("tbl%0d_drop", r), 32'(drop_count), 32'(tbl[r].drop));
    end

    // Coalescing while the queue is full.
    step(6'b001111, 1'b1, 1'b0);
    repeat (4) step(6'b000000, 1'b1, 1'b0);
    repeat (3) step(6'b000100, 1'b1, 1'b0);
    chk("coal_pending", 32'(pending), 32'h04);
    chk("coal_drop", 32'(drop_count), 32'd2);
    chk("coal_valid", 32'(msg_valid), 32'd1);
    step(6'b000000, 1'b1, 1'b1);
    chk("coal_enq_pending", 32'(pending), 32'h0);
    chk("coal_enq_valid", 32'(msg_valid), 32'd1);
    repeat (5) step(6'b000000, 1'b1, 1'b1);
    chk("coal_drained", 32'(msg_valid), 32'd0);
    chk("coal_sb_empty", 32'(sb.size()), 32'd0);

    // Six events across the pointer wrap with irregular acknowledge.
    p0 = popped;
    step(6'b111111, 1'b1, 1'b0);
    repeat (5) step(6'b000000, 1'b1, 1'b0);
    chk("wrap_pending", 32'(pending), 32'h30);
    for (int c = 0; c < 20; c++) step(6'b000000, 1'b1, 1'($urandom_range(0, 2) != 0));
    repeat (8) step(6'b000000, 1'b1, 1'b1);
    chk("wrap_popped", 32'(popped - p0), 32'd6);
    chk("wrap_valid", 32'(msg_valid), 32'd0);
    chk("wrap_drop", 32'(drop_count), 32'd2);

    // Flush with Enable low.
    step(6'b010111, 1'b1, 1'b0);
    repeat (3) step(6'b000000, 1'b1, 1'b0);
    chk("flush_pre_pending", 32'(pending), 32'h10);
    chk("flush_pre_header", header, 32'h017F0400);
    step(6'b101010, 1'b0, 1'b1);
    chk("flush_valid", 32'(msg_valid), 32'd0);
    chk("flush_pending", 32'(pending), 32'h0);
    chk("flush_drop", 32'(drop_count), 32'd2);
    step(6'b000000, 1'b1, 1'b0);

    // Asynchronous reset between edges with the queue non-empty.
    step(6'b000011, 1'b1, 1'b0);
    repeat (2) step(6'b000000, 1'b1, 1'b0);
    chk("prereset_valid", 32'(msg_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(msg_valid), 32'd0);
    chk("arst_header", header, 32'h0);
    chk("arst_drop", 32'(drop_count), 32'd0);
    chk("arst_pending", 32'(pending), 32'd0);
    mpend = '0;
    mdrop = '0;
    mq.delete();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) step(6'b000000, 1'b1, 1'b1);
    step(6'b001000, 1'b1, 1'b0);
    repeat (2) step(6'b000000, 1'b1, 1'b0);
    chk("post_reset_header", header, 32'h017F0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/error_response_queue.md
# error_response_queue

Parametrised error-response generator for the USB Type-C authentication driver. It latches error events from any number of request-decoding sources and arbitrates them by fixed priority. It queues the resulting ERROR response headers in a small FIFO and hands them to the message transmitter over a valid/acknowledge handshake. Unlike a single-shot error encoder, it loses no events while the transmitter is busy, coalesces repeats, and counts drops.

## Interface
- NUM_ERRORS, 6: number of error source lines; index 0 has highest priority.
- HDR_VAR_W, 8: width of one header field (SIZE_OF_HEADER_VARS).
- HDR_BYTES, 4: header fields per message (SIZE_OF_HEADER_IN_BYTES); fixed layout requires 4.
- FIFO_DEPTH, 4: queued headers, power of two, ≥2.
- PROTOCOL_VERSION, 8'h01: header field 3.
- ERROR_RESP_CMD, 8'h7F: header field 2.
- ERR_CODE_MAP, {6{16'h0100}} with entry 1 = 16'h0201, entry 2 = 16'h0300, entry 0 = 16'h0400: NUM_ERRORS×16 bits; entry i (bits 16i+15:16i) = {Param1, Param2} for source i.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Enable  in  1  block enable; low flushes all pending and queued errors.
- error_in  in  NUM_ERRORS  error event lines, one per source, sampled every cycle.
- header  out  HDR_VAR_W×HDR_BYTES  {PROTOCOL_VERSION, ERROR_RESP_CMD, Param1, Param2} of FIFO head; zero when empty.
- msg_valid  out  1  FIFO not empty.
- msg_ack  in  1  transmitter consumed header; effective only with msg_valid.
- pending  out  NUM_ERRORS  latched, not yet queued errors.
- drop_count  out  8  saturating count of coalesced/discarded events.

## Operation
- Reset (rst_n low, asynchronous): pending=0, FIFO empty (rd/wr pointers 0, count 0), msg_valid=0, header=0, drop_count=0.
- Capture: each cycle with Enable high, pending[i] <= pending[i] | error_in[i], except as cleared by enqueue below.
- Coalescing: error_in[i] high while pending[i] already set and not being cleared that cycle increments drop_count (saturate at 255); event is merged.
- Arbitration: lowest set index of pending selected; enqueue when FIFO has room (count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop this cycle).
- Enqueue writes source index into FIFO, clears that pending bit. If error_in of the same index is high that cycle, the bit stays set (set wins; no drop counted).
- Only one enqueue per cycle; lower-priority pending bits wait.
- FIFO full with pending nonzero: events remain pending (no drop); only coalescing drops.
- Dequeue: msg_valid && msg_ack at edge pops head; msg_ack with msg_valid low ignored.
- header formed from head index via ERR_CODE_MAP; stable while msg_valid high and not popped.
- Enable low (synchronous): next edge clears pending, empties FIFO, ignores error_in and msg_ack; drop_count holds.

## Timing
- error_in high at edge N → pending bit set after N; enqueued at edge N+1 (FIFO not full, highest priority) → msg_valid/header valid after N+1: 2-cycle latency.
- Pop at edge M → next header (if any) visible after M; back-to-back pops each cycle allowed.
- Simultaneous push+pop when full: both occur, count unchanged.
- Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.
- rst_n asserted mid-transfer: outputs go to reset values immediately, no edge needed.

## Test plan
- Single event: error_in=6'b000100 one cycle, msg_ack=0 → after 2 edges msg_valid=1, header=32'h017F0300; ack → msg_valid=0.
- Priority: error_in=6'b100011 one cycle, ack held high → headers 32'h017F0400, 32'h017F0201, 32'h017F0100 on consecutive cycles, pending=0 afterwards, drop_count=0.
- Coalesce: error_in[2] pulsed 3 cycles while FIFO full (4 queued, no ack) → pending[2]=1, drop_count=2; after one ack bit 2 enqueued once.
- Full wrap: 6 events across pointer wrap with irregular ack → headers emerge in arbitration order, none lost, msg_valid drops only when all consumed.
- Flush: 3 headers queued, pending=6'b010000, Enable low one cycle → msg_valid=0, pending=0, drop_count unchanged.
- Async reset: rst_n low between edges with FIFO non-empty → msg_valid, header, drop_count zero immediately.
